ext_out_port: RTL and testbench

- CPU-side driver for the 8-bit external data bus that the motherboard shows on its two 7-segment LED digits.
- Accepts bytes from the CPU core over a valid/ready write interface and buffers them in a small FIFO.
- Presents each byte on ExtD for a fixed, human-visible hold time. Back-to-back CPU writes are therefore not lost on the display.
- After the queue drains, the last byte stays on ExtD.

---
 rtl/ext_out_port_if.sv | 19 +
 rtl/ext_out_port.sv | 117 +++++++++++
 tb/tb_ext_out_port.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_out_port_if.sv
// Write channel from the CPU core into the external LED data port.
// The CPU side drives a byte with a valid flag; the port answers with ready.
interface ext_out_port_if;
    logic       WR_VALID;
    logic [7:0] WR_DATA;
    logic       WR_READY;

    modport master (
        output WR_VALID,
        output WR_DATA,
        input  WR_READY
    );

    modport slave (
        input  WR_VALID,
        input  WR_DATA,
        output WR_READY
    );
endinterface

// File: rtl/ext_out_port.sv
// CPU-side driver for the 8-bit external data bus feeding the two 7-segment
// LED digits. Bytes written by the CPU are queued in a small FIFO and each one
// is held on ExtD for HOLD_CYCLES clocks, so a burst of writes stays readable.
// When the queue runs dry the last byte remains on the bus.
module ext_out_port #(
    parameter int DEPTH       = 4,        // FIFO entries, power of two 2..16
    parameter int HOLD_CYCLES = 3300000   // clocks each byte stays on ExtD, >= 1
) (
    input  logic                   CLK_33,
    input  logic                   RST,
    ext_out_port_if.slave          wr,
    output logic [7:0]             ExtD,
    output logic                   BUSY,
    output logic [$clog2(DEPTH):0] LEVEL
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic push;
    logic pop;
    logic not_empty;

    // Ready looks only at the registered level, so a full FIFO refuses a
    // write even on an edge where the display is about to pop an entry.
    assign wr.WR_READY = (LEVEL < FULL_LEVEL);
    assign not_empty   = (LEVEL != '0);
    assign push        = wr.WR_VALID && wr.WR_READY;

    // A byte leaves the queue when the display is idle, or when the current
    // byte has finished its hold window (back-to-back, no gap cycle).
    assign pop = not_empty && ((state == IDLE) || (hold_cnt == '0));

    // Byte storage: written at the tail on every accepted write.
    // NOTE: the storage array has no reset; the pointers and level alone
    // decide which entries are valid, so stale contents are never shown.
    always_ff @(posedge CLK_33) begin
        if (push) begin
            mem[wr_ptr] <= wr.WR_DATA;
        end
    end

    // Queue bookkeeping: head/tail pointers wrap modulo DEPTH, level tracks occupancy.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // sees the values from before the edge, regardless of statement order.
    always_ff @(posedge CLK_33 or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + LVL_W'(1);
                2'b01:   LEVEL <= LEVEL - LVL_W'(1);
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    // Display sequencer: loads the head byte onto ExtD and times its hold window.
    always_ff @(posedge CLK_33 or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ExtD     <= 8'h00;
            BUSY     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        ExtD     <= mem[rd_ptr];
                        hold_cnt <= HOLD_RELOAD;
                        BUSY     <= 1'b1;
                        state    <= SHOW;
                    end
                end
                SHOW: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end else if (pop) begin
                        ExtD     <= mem[rd_ptr];
                        hold_cnt <= HOLD_RELOAD;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_out_port.sv
// Self-checking bench for ext_out_port with DEPTH=4, HOLD_CYCLES=4.
// The reference is a display schedule: each accepted byte gets a start edge
// max(accept_edge+1, previous_start+HOLD); outputs follow from that schedule.
module tb_ext_out_port;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       ext_d;
    logic             busy;
    logic [LVL_W-1:0] level;

    ext_out_port_if wr_if ();

    ext_out_port #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK_33 (clk),
        .RST    (rst),
        .wr     (wr_if),
        .ExtD   (ext_d),
        .BUSY   (busy),
        .LEVEL  (level)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- schedule model ----------------
    logic [7:0] pend_data [$];
    int         pend_start[$];
    logic [7:0] m_ext       = 8'h00;
    logic       m_busy      = 1'b0;
    int         m_level     = 0;
    int         shown_start = -1000;
    int         last_sched  = -1000;
    int         edge_cnt    = 0;
    int         s_new;
    bit         ready_pre;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data.delete();
            pend_start.delete();
            m_ext       = 8'h00;
            m_busy      = 1'b0;
            m_level     = 0;
            shown_start = -1000;
            last_sched  = -1000;
        end else begin
            edge_cnt++;
            ready_pre = (pend_data.size() < DEPTH);
            if (pend_start.size() > 0 && pend_start[0] == edge_cnt) begin
                m_ext       = pend_data.pop_front();
                shown_start = pend_start.pop_front();
            end
            if (wr_if.WR_VALID && ready_pre) begin
                s_new = (edge_cnt + 1 > last_sched + HOLD) ? edge_cnt + 1 : last_sched + HOLD;
                pend_data.push_back(wr_if.WR_DATA);
                pend_start.push_back(s_new);
                last_sched = s_new;
            end
            m_level = pend_data.size();
            m_busy  = (edge_cnt < shown_start + HOLD);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_ExtD",     ext_d,          m_ext);
            check("model_BUSY",     busy,           m_busy);
            check("model_LEVEL",    level,          m_level);
            check("model_WR_READY", wr_if.WR_READY, m_level < DEPTH);
        end
    end

    // ---------------- display log for burst analysis ----------------
    bit         log_on = 1'b0;
    logic [7:0] log_q[$];
    bit         ready_low_seen;
    int         max_level;

    always @(negedge clk) begin
        if (log_on) begin
            log_q.push_back(ext_d);
            if (!wr_if.WR_READY) ready_low_seen = 1'b1;
            if (int'(level) > max_level) max_level = level;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge, WR_VALID left high.
    task automatic send(input logic [7:0] d, output int acc_edge, output int refused);
        bit rdy;
        bit done = 1'b0;
        refused  = 0;
        acc_edge = -1;
        wr_if.WR_VALID = 1'b1;
        wr_if.WR_DATA  = d;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = wr_if.WR_READY;
            @(posedge clk);
            #1;
            if (rdy) begin
                done     = 1'b1;
                acc_edge = edge_cnt;
            end else begin
                refused++;
            end
        end
        check("send_accepted", done, 1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (!busy && level == 0) got = 1'b1;
        end
        check("idle_reached", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int acc[6];
    int rf[6];
    int busy_cnt;
    int cnt;
    int fi[6];
    bit ordered;

    initial begin
        wr_if.WR_VALID = 1'b0;
        wr_if.WR_DATA  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ExtD",  ext_d, 8'h00);
        check("rst_LEVEL", level, 0);
        check("rst_BUSY",  busy, 0);
        check("rst_READY", wr_if.WR_READY, 1);
        @(posedge clk);
        #1;

        // Single write 0xA5: visible one edge after acceptance, BUSY for 4 cycles
        send(8'hA5, acc[0], rf[0]);
        wr_if.WR_VALID = 1'b0;
        @(negedge clk);
        check("t1_ext_before", ext_d, 8'h00);
        check("t1_level",      level, 1);
        @(negedge clk);
        check("t1_ext_shown", ext_d, 8'hA5);
        busy_cnt = busy;
        repeat (8) begin
            @(negedge clk);
            busy_cnt += busy;
        end
        check("t1_busy_len",  busy_cnt, 4);
        check("t1_ext_kept",  ext_d, 8'hA5);
        @(posedge clk);
        #1;

        // Burst 01..05 with WR_VALID held high
        log_q.delete();
        ready_low_seen = 1'b0;
        max_level      = 0;
        log_on         = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(i + 1), acc[i], rf[i]);
        wr_if.WR_VALID = 1'b0;
        wait_idle();
        log_on = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            cnt = 0;
            foreach (log_q[j]) if (log_q[j] == 8'(v)) cnt++;
            check("t2_hold_len", cnt, 4);
        end
        for (int v = 1; v <= 5; v++) begin
            fi[v] = -1;
            foreach (log_q[j]) if (log_q[j] == 8'(v) && fi[v] < 0) fi[v] = j;
        end
        ordered = (fi[1] >= 0);
        for (int v = 2; v <= 5; v++) if (fi[v] <= fi[v-1]) ordered = 1'b0;
        check("t2_order",      ordered, 1);
        check("t2_ready_low",  ready_low_seen, 1);
        check("t2_max_level",  max_level, 4);
        check("t2_accept_span", acc[4] - acc[0], 4);
        check("t2_ext_last",   ext_d, 8'h05);

        // Write landing exactly on a pop edge with LEVEL=2
        send(8'h31, acc[0], rf[0]);
        send(8'h32, acc[1], rf[1]);
        send(8'h33, acc[2], rf[2]);
        wr_if.WR_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_if.WR_VALID = 1'b1;
        wr_if.WR_DATA  = 8'h34;
        @(negedge clk);
        check("t3_level_pre", level, 2);
        check("t3_ext_pre",   ext_d, 8'h31);
        @(posedge clk);
        #1;
        wr_if.WR_VALID = 1'b0;
        @(negedge clk);
        check("t3_level_post", level, 2);
        check("t3_ext_post",   ext_d, 8'h32);
        wait_idle();
        check("t3_ext_last", ext_d, 8'h34);

        // Full FIFO: write refused on the pop edge, accepted on the next one
        for (int i = 0; i < 6; i++) send(8'(8'h21 + i), acc[i], rf[i]);
        wr_if.WR_VALID = 1'b0;
        check("t4_fill_span",   acc[4] - acc[0], 4);
        check("t4_refusals",    rf[5], 1);
        check("t4_accept_next", acc[5] - acc[4], 2);
        wait_idle();
        check("t4_ext_last", ext_d, 8'h26);

        // Asynchronous reset during the second byte's hold, two bytes queued
        for (int i = 0; i < 4; i++) send(8'(8'h41 + i), acc[i], rf[i]);
        wr_if.WR_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_ext_pre",   ext_d, 8'h42);
        check("t5_level_pre", level, 2);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ExtD",  ext_d, 8'h00);
        check("t5_rst_LEVEL", level, 0);
        check("t5_rst_BUSY",  busy, 0);
        check("t5_rst_READY", wr_if.WR_READY, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_stale_ext", ext_d, 8'h00);
        check("t5_no_stale_lvl", level, 0);
        check("t5_no_stale_bsy", busy, 0);
        @(posedge clk);
        #1;

        // Pointer wrap: ten single writes, each after the previous hold ends
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h10 + i), acc[0], rf[0]);
            wr_if.WR_VALID = 1'b0;
            wait_idle();
            check("t6_ext", ext_d, 8'(8'h10 + i));
        end
        check("t6_level_final", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
